receptor_paridade: RTL

Serial receiver and parity checker for the 9-bit protected word (bits 0–7 data, bit 8 even parity). It is the consuming end of the parity link, downstream of the error injector. It accepts one bit per handshake, LSB first, and reassembles the word. It checks parity, presents the data byte with an error flag on a valid/ready output port, and tracks errors with a sticky flag and a saturating counter.

---
 rtl/receptor_paridade_pkg.sv | 11 +
 rtl/receptor_paridade_calcula_paridade.sv | 9 +
 rtl/receptor_paridade.sv | 115 +++++++++++
 3 files changed

// File: rtl/receptor_paridade_pkg.sv
// Shared definitions for the parity link (transmitter, injector, receiver).
package pacote_paridade;
  localparam int WORD_W     = 9;
  localparam int DATA_W     = 8;
  localparam int PARITY_IDX = 8;

  typedef enum logic {
    RECEBE  = 1'b0,
    ENTREGA = 1'b1
  } estado_t;
endpackage

// File: rtl/receptor_paridade_calcula_paridade.sv
// XOR reduction of a protected word; 0 means even parity holds.
module calcula_paridade #(
  parameter int W = 9
) (
  input  logic [W-1:0] word,
  output logic         paridade
);
  assign paridade = ^word;
endmodule

// File: rtl/receptor_paridade.sv
// Serial LSB-first receiver with even-parity check and error tracking.
// Define RECEPTOR_PARIDADE_CONTADOR_EN to build the saturating error counter.
//
// state   | meaning
// RECEBE  | shifting bits into word[idx]; in_ready=1
// ENTREGA | holding dado/erro_paridade; out_valid=1
module receptor_paridade
  import pacote_paridade::*;
#(
  parameter int DATA_W = pacote_paridade::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] dado,
  output logic              erro_paridade,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              limpa,
  output logic              erro_flag,
  output logic [CNT_W-1:0]  erro_count
);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W);

  estado_t           estado;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W:0]   word;
  logic [DATA_W:0]   word_next;
  logic              paridade;
  logic              fim;

  always_comb begin
    word_next = word;
    for (int i = 0; i <= DATA_W; i++) begin
      if (idx == IDX_W'(i)) word_next[i] = bit_in;
    end
  end

  // Parity is taken over the word including the bit accepted this cycle.
  calcula_paridade #(.W(DATA_W + 1)) u_paridade (
    .word     (word_next),
    .paridade (paridade)
  );

  assign fim       = (estado == RECEBE) && in_valid && (idx == IDX_LAST);
  assign in_ready  = (estado == RECEBE);
  assign out_valid = (estado == ENTREGA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado        <= RECEBE;
      idx           <= '0;
      word          <= '0;
      dado          <= '0;
      erro_paridade <= 1'b0;
    end else begin
      case (estado)
        RECEBE: begin
          if (in_valid) begin
            word <= word_next;
            if (idx == IDX_LAST) begin
              dado          <= word_next[DATA_W-1:0];
              erro_paridade <= paridade;
              idx           <= '0;
              estado        <= ENTREGA;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ENTREGA: begin
          if (out_ready) estado <= RECEBE;
        end
        default: estado <= RECEBE;
      endcase
    end
  end

  // An error completing on the same edge as limpa wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      erro_flag <= 1'b0;
    end else if (fim && paridade) begin
      erro_flag <= 1'b1;
    end else if (limpa) begin
      erro_flag <= 1'b0;
    end
  end

`ifdef RECEPTOR_PARIDADE_CONTADOR_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;

  assign cnt_base = limpa ? '0 : cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (fim && paridade && (cnt_base != '1)) begin
      cnt <= cnt_base + 1'b1;
    end else begin
      cnt <= cnt_base;
    end
  end

  assign erro_count = cnt;
`else
  assign erro_count = '0;
`endif

endmodule
